pipe_buf_stage: RTL and testbench

Parametrised elastic pipeline buffer stage that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the RISC-V pipeline. It carries an opaque packed payload of WIDTH bits between two stages with valid/ready handshaking, a 2-entry skid buffer so `in_ready` is registered, a synchronous flush for branch/hazard squashing, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_buf_pkg.sv | 70 +++++++
 rtl/pipe_buf_stage_sat_counter.sv | 40 ++++
 rtl/pipe_buf_stage.sv | 125 ++++++++++++
 tb/tb_pipe_buf_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_buf_pkg.sv
// Shared types for the elastic pipeline buffer stage: buffer state encoding,
// the payload structs carried across each RISC-V pipeline boundary, and the
// payload widths each pipe_buf_stage instance should use for WIDTH.
package pipe_buf_pkg;

    // Buffer fill state; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pbuf_state_e;

    // Fetch -> decode boundary.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // Decode -> execute boundary.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        is_branch;
    } id_ex_t;

    // Execute -> memory boundary.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  mem_size;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    // Memory -> writeback boundary.
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // Payload widths so each instance sets WIDTH straight from its struct.
    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Number of entries held for a given buffer state.
    function automatic logic [1:0] pbuf_occupancy(input pbuf_state_e st);
        logic [1:0] occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_buf_stage_sat_counter.sv
// Saturating up-counter: counts cycles where inc is high and sticks at the
// all-ones value instead of wrapping. Cleared only by the synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] r_count;
    logic         w_bump;

    // Only step when requested and not already pinned at the ceiling.
    always_comb begin
        w_bump = 1'b0;
        if (inc && (r_count != MAX_VAL)) begin
            w_bump = 1'b1;
        end else begin
            w_bump = 1'b0;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= {W{1'b0}};
        end else if (w_bump) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_buf_stage.sv
// Elastic pipeline buffer stage: a two-entry skid buffer between two
// valid/ready interfaces. in_ready and out_data come straight from registers,
// so neither direction has a combinational path through the stage. flush
// squashes everything held; a stall counter records downstream backpressure.
module pipe_buf_stage
    import pipe_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pbuf_state_e      r_state;
    pbuf_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;
    logic w_stall;

    // Interface outputs are pure decodes of the state/data registers.
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != FULL);
    assign out_data  = r_main;
    assign occupancy = pbuf_occupancy(r_state);

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_stall    = out_valid && !out_ready;

    // Next-state and data-load decode; flush overrides any handshake and
    // leaves the data registers alone.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end else begin
                        w_state_nxt = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_state_nxt      = ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end else begin
                        w_state_nxt = FULL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset wins over flush and handshakes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_main  <= {WIDTH{1'b0}};
            r_skid  <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end else begin
                r_main <= r_main;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end else begin
                r_skid <= r_skid;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_stall),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Directed bench for pipe_buf_stage: inputs change and outputs are sampled
// 1 ns after each rising edge. CNT_W is 3 so saturation is reachable quickly.
module tb_pipe_buf_stage;

    localparam int WIDTH = 64;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp;
    int n_bad;

    pipe_buf_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 64'd0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (out_data !== 64'd0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'(i)) begin n_bad++; $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 64'(i)); end
            n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 64'hA) begin n_bad++; $display("FAIL bp_first: got occ=%0d rdy=%b d=%h want occ=1 rdy=1 d=a", occupancy, in_ready, out_data); end
        in_data = 64'hB;
        tick();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'hA) begin n_bad++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a", occupancy, in_ready, out_data); end
        in_data = 64'hC;
        tick();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'hA) begin n_bad++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a", occupancy, in_ready, out_data); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 64'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_drain_b: got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1", out_data, occupancy, in_ready); end
        tick();
        n_cmp++; if (out_data !== 64'hC || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_bad++; $display("FAIL bp_drain_c: got d=%h v=%b occ=%0d want d=c v=1 occ=1", out_data, out_valid, occupancy); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got v=%b want 0", out_valid); end
        // Stalled edges: one in ONE, one in FULL.
        n_cmp++; if (stall_cnt !== 3'd2) begin n_bad++; $display("FAIL bp_stall: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        tick();
        in_data = 64'h22;
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL ff_fill: got occ=%0d want 2", occupancy); end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin n_bad++; $display("FAIL ff_flushed: got v=%b rdy=%b occ=%0d want v=0 rdy=1 occ=0", out_valid, in_ready, occupancy); end
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h33;
        tick();
        n_cmp++; if (out_data !== 64'h33 || occupancy !== 2'd1) begin n_bad++; $display("FAIL ff_new_beat: got d=%h occ=%0d want d=33 occ=1", out_data, occupancy); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ff_alone: got v=%b d=%h want v=0", out_valid, out_data); end
        n_cmp++; if (stall_cnt !== 3'd3) begin n_bad++; $display("FAIL ff_stall: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_flush_empty();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h55;
        out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL fe_squash: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fe_still_empty: got v=%b want 0", out_valid); end
        n_cmp++; if (out_data !== 64'h33) begin n_bad++; $display("FAIL fe_data_kept: got %h want 33", out_data); end
    endtask

    task automatic test_saturation();
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (stall_cnt !== ((k > 7) ? 3'd7 : 3'(k))) begin n_bad++; $display("FAIL sat_step%0d: got %0d want %0d", k, stall_cnt, (k > 7) ? 7 : k); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (stall_cnt !== 3'd7 || out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_flush: got cnt=%0d v=%b want cnt=7 v=0", stall_cnt, out_valid); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL sat_reset: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA1;
        tick();
        in_data = 64'hA2;
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL rm_fill: got occ=%0d want 2", occupancy); end
        reset_n   = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = 64'hA3;
        tick();
        reset_n = 1'b1;
        flush   = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 64'd0 || stall_cnt !== 3'd0) begin n_bad++; $display("FAIL rm_reset: got v=%b rdy=%b occ=%0d d=%h cnt=%0d want 0/1/0/0/0", out_valid, in_ready, occupancy, out_data, stall_cnt); end
        in_valid = 1'b1;
        in_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL rm_after: got v=%b d=%h want v=1 d=0123456789abcdef", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_drain: got v=%b want 0", out_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_empty();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
